mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single 128-bit-block main-memory port between the instruction cache (refill reads only) and the data cache (refill reads and dirty-block write-backs). It sits between the caches and main memory. It serialises miss traffic with round-robin fairness and latches each transfer's request and result. It also flags a memory that never completes a transfer.

## Interface
- ADDR_W, 28: block address width (byte address [31:4]).
- BLOCK_W, 128: cache block width in bits.
- TIMEOUT, 255: maximum WAIT cycles before a transfer is aborted; range 1..65535.

- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- I_READ  in  1  icache refill request; held until I_BUSYWAIT falls.
- I_ADDRESS  in  ADDR_W  icache block address.
- I_READDATA  out  BLOCK_W  refill block to icache.
- I_BUSYWAIT  out  1  icache stall.
- D_READ  in  1  dcache refill request.
- D_WRITE  in  1  dcache write-back request; wins if D_READ is also high.
- D_ADDRESS  in  ADDR_W  dcache block address.
- D_WRITEDATA  in  BLOCK_W  write-back block.
- D_READDATA  out  BLOCK_W  refill block to dcache.
- D_BUSYWAIT  out  1  dcache stall.
- MEM_READ, MEM_WRITE  out  1 each  memory commands.
- MEM_ADDRESS  out  ADDR_W  latched block address.
- MEM_WRITEDATA  out  BLOCK_W  latched write data.
- MEM_READDATA  in  BLOCK_W  memory read block.
- MEM_BUSYWAIT  in  1  memory busy; low means transfer complete.
- ERR  out  1  sticky timeout flag.

## Operation
- **State machine**
  - IDLE: no owner.
  - ISSUE: 1 cycle; drive the memory command.
  - WAIT: hold the command until memory completes.
  - DONE: 1 cycle; release the owner.
- **IDLE**
  - Sample I_READ and D_READ|D_WRITE each edge.
  - None pending: stay in IDLE.
  - One pending: grant it.
  - Both pending: grant the requester that is not LAST_OWNER.
  - On grant: latch owner, op, address and write data (for a write); go to ISSUE.
- **ISSUE / WAIT command outputs**
  - MEM_READ = 1 for a read op; MEM_WRITE = 1 for a write op.
  - MEM_ADDRESS and MEM_WRITEDATA come from the latch, not live inputs.
  - All memory outputs are 0 in IDLE and DONE.
- **ISSUE -> WAIT** unconditionally. This gives memory one edge to raise MEM_BUSYWAIT.
- **WAIT -> DONE** at the first edge where MEM_BUSYWAIT = 0.
  - On a read, latch MEM_READDATA into the owner's READDATA register.
  - Update LAST_OWNER = owner.
- **Timeout**
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT: go to DONE, set ERR = 1, and force the owner's READDATA to 0.
  - ERR stays set until reset.
- **DONE -> IDLE** unconditionally.
- **Requester stalls** (combinational)
  - I_BUSYWAIT = I_READ & ~(state==DONE & owner==I).
  - D_BUSYWAIT = (D_READ|D_WRITE) & ~(state==DONE & owner==D).
- **Request dropped mid-transfer:** the memory transaction still completes, the result is still latched, and the requester sees no effect.
- **Non-owner READDATA** holds its last value.

## Timing
- **Reset values**
  - state = IDLE, LAST_OWNER = I (so D wins the first tie).
  - ERR = 0, counter = 0, all latches = 0.
  - I_READDATA = D_READDATA = 0.
  - MEM_READ = MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0.
  - Busywaits follow their combinational equations.
- **Latency** from a request seen in IDLE to its BUSYWAIT falling is 3 + W cycles. W is the number of WAIT cycles, W >= 1.
- **Back-to-back:** a requester re-asserting straight after DONE is re-arbitrated in IDLE. It loses any tie to the other requester.
- **Reset mid-transfer:** everything returns to reset values immediately and no transfer is replayed. Requesters still asserting see BUSYWAIT = 1 and are re-granted after reset is released.
- **Counter:** saturates and never wraps. TIMEOUT = 1 aborts after one WAIT cycle with MEM_BUSYWAIT high.

## Test plan
- Lone icache read of address 0x0000010; memory busy for 4 cycles, returns 0xA5..A5 -> I_READDATA = 0xA5..A5, I_BUSYWAIT falls in the DONE cycle, MEM_WRITE never asserted.
- I_READ and D_WRITE raised together just after reset -> D served first (MEM_WRITE with latched D_WRITEDATA), then I (MEM_READ); each BUSYWAIT falls in its own DONE cycle.
- Both requesters continuously re-requesting for 6 transfers -> grant order alternates D, I, D, I, D, I.
- D_ADDRESS changed during WAIT -> MEM_ADDRESS stays at the latched value through the whole transfer.
- MEM_BUSYWAIT held high with TIMEOUT = 8 -> DONE after 8 WAIT cycles, ERR = 1, owner READDATA = 0; ERR stays 1 across later good transfers.
- RESET asserted during WAIT of a dcache read -> MEM_READ = 0 immediately and ERR = 0; after release the still-pending D_READ is re-issued with state passing IDLE then ISSUE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide main-memory port between the
// instruction-cache refill path and the data-cache refill/write-back path.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait,
  output logic               err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t      state;
  owner_t      owner;
  owner_t      last_owner;
  logic [15:0] cnt;

  logic        i_req;
  logic        d_req;
  logic        grant_d;
  logic [16:0] cnt_inc;
  logic        timeout_hit;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  // On a tie the requester that was not served last wins.
  assign grant_d = d_req & (~i_req | (last_owner == OWN_I));

  assign cnt_inc     = {1'b0, cnt} + 17'd1;
  assign timeout_hit = (cnt_inc >= TIMEOUT_L);

  assign i_busywait = i_req & ~((state == ST_DONE) & (owner == OWN_I));
  assign d_busywait = d_req & ~((state == ST_DONE) & (owner == OWN_D));

  // NOTE: every register, including the block-wide data registers, is cleared
  // by the async reset so a reset mid-transfer leaves no stale command or data;
  // all state updates use non-blocking assignments so same-edge reads see the
  // pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      owner         <= OWN_I;
      last_owner    <= OWN_I;
      cnt           <= '0;
      err           <= 1'b0;
      i_readdata    <= '0;
      d_readdata    <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req | d_req) begin
            owner         <= grant_d ? OWN_D : OWN_I;
            mem_read      <= grant_d ? ~d_write : 1'b1;
            mem_write     <= grant_d & d_write;
            mem_address   <= grant_d ? d_address : i_address;
            mem_writedata <= (grant_d & d_write) ? d_writedata : '0;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!mem_busywait || timeout_hit) begin
            if (mem_busywait) begin
              // Aborted transfer: flag it and hand the owner an all-zero block.
              err <= 1'b1;
              if (owner == OWN_I) i_readdata <= '0;
              else                d_readdata <= '0;
            end else if (mem_read) begin
              if (owner == OWN_I) i_readdata <= mem_readdata;
              else                d_readdata <= mem_readdata;
            end
            last_owner    <= owner;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            state         <= ST_DONE;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
